// File: rtl/cwt_pkg.sv
// cwt_pkg
// Shared definitions for the CWT result drain path.
//   tx_state_t      : drain sequencer states (idle, issuing reads, draining)
//   TLAST_PER_*     : selects where the stream packet boundary falls
//   addrWidth()     : BRAM address width for a frame of n*j1 words
//   scaleWidth()    : width of a scale index for j1 scales
package cwt_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_READ  = 2'd1,
        TX_DRAIN = 2'd2
    } tx_state_t;

    localparam int TLAST_PER_FRAME = 0;
    localparam int TLAST_PER_SCALE = 1;

    // Width of an address covering n*j1 words; never narrower than one bit.
    function automatic int addrWidth(input int n, input int j1);
        return (n * j1 > 1) ? $clog2(n * j1) : 1;
    endfunction

    // Width of a scale index for j1 scales; never narrower than one bit.
    function automatic int scaleWidth(input int j1);
        return (j1 > 1) ? $clog2(j1) : 1;
    endfunction

endpackage

// File: rtl/cwt_skid_fifo.sv
// cwt_skid_fifo
// Two-entry FIFO whose head entry is a register, so the stream outputs
// come straight from flops and stay stable while the consumer stalls.
//   clk, rstn   : clock, asynchronous active-low reset
//   i_push      : write i_data this cycle
//   i_pop       : remove the head entry this cycle (ignored when empty)
//   i_data      : entry to write
//   o_data      : head entry
//   o_full      : two entries held
//   o_empty     : no entries held
//   o_count     : number of entries held (0..2)
module cwt_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             w_pop;

    assign w_pop = i_pop && (r_count != 2'd0);

    // The head register is the output. The tail only feeds the head when
    // the head leaves while a second entry is waiting, so a stalled head
    // never changes. A push and a pop together are legal even when full.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head  <= i_data;
                        r_count <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_tail  <= i_data;
                        r_count <= 2'd2;
                    end
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end else begin
                        r_head <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_data  = r_head;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/cwt_axis_tx.sv
// cwt_axis_tx
// Drains a complete CWT result frame (J1 scales of N coefficients) from
// the result BRAM, reading every word once in address order, and emits it
// as an AXI4-Stream master with full backpressure.
//   clk, rstn          : clock, asynchronous active-low reset
//   start_i            : one-cycle pulse, begin draining a frame (idle only)
//   bram_en_o          : BRAM read enable
//   bram_addr_o        : BRAM read address (0 when not reading)
//   bram_dout_i        : BRAM read data, valid one cycle after bram_en_o
//   m_axis_tdata       : stream data
//   m_axis_tvalid      : stream valid
//   m_axis_tready      : stream ready
//   m_axis_tlast       : last beat of frame or of scale (TLAST_MODE)
//   m_axis_tuser       : scale index of the current beat
//   busy_o             : frame in progress
//   done_o             : one-cycle pulse after the final beat is accepted
module cwt_axis_tx
    import cwt_pkg::*;
#(
    parameter int N          = 1024,
    parameter int J1         = 64,
    parameter int DW         = 32,
    parameter int TLAST_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start_i,
    output logic                       bram_en_o,
    output logic [addrWidth(N,J1)-1:0] bram_addr_o,
    input  logic [DW-1:0]              bram_dout_i,
    output logic [DW-1:0]              m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [scaleWidth(J1)-1:0]  m_axis_tuser,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int AW = addrWidth(N, J1);
    localparam int UW = scaleWidth(J1);
    localparam int CW = AW + 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = DW + 1 + UW;
    localparam logic [CW-1:0] LAST_ADDR  = CW'(N * J1 - 1);
    localparam logic [CW-1:0] SCALE_MASK = CW'(N - 1);

    tx_state_t     r_state;
    logic [CW-1:0] r_rdAddr;
    logic [CW-1:0] r_beatCnt;
    logic          r_inflight;
    logic          r_inflightLast;
    logic [UW-1:0] r_inflightUser;
    logic          r_busy;
    logic          r_done;

    logic          w_pop;
    logic          w_issue;
    logic          w_issueLast;
    logic [UW-1:0] w_issueUser;
    logic          w_finalBeat;
    logic [2:0]    w_occ;
    logic [FW-1:0] w_fifoIn;
    logic [FW-1:0] w_fifoOut;
    logic          w_full;
    logic          w_empty;
    logic [1:0]    w_count;

    // Occupancy counts words already in the FIFO plus the one still coming
    // out of the BRAM. A read is only issued when its word is guaranteed a
    // slot: below two, or at two when a beat leaves this same cycle.
    assign w_pop   = !w_empty && m_axis_tready;
    assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight};
    assign w_issue = (r_state == TX_READ) &&
                     ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop));

    assign w_issueUser = UW'(r_rdAddr >> NW);
    assign w_issueLast = (TLAST_MODE == TLAST_PER_SCALE)
                       ? ((r_rdAddr & SCALE_MASK) == SCALE_MASK)
                       : (r_rdAddr == LAST_ADDR);

    assign w_finalBeat = (r_state == TX_DRAIN) && w_pop && (r_beatCnt == LAST_ADDR);

    assign bram_en_o   = w_issue;
    assign bram_addr_o = w_issue ? r_rdAddr[AW-1:0] : '0;

    // Sequencer: reads are issued in READ until the last address goes out,
    // then DRAIN waits for the final beat to be accepted. The beat counter
    // identifies the final handshake independently of the tlast mode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= TX_IDLE;
            r_rdAddr  <= '0;
            r_beatCnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) begin
                r_beatCnt <= r_beatCnt + CW'(1);
            end
            case (r_state)
                TX_IDLE: begin
                    if (start_i) begin
                        r_state   <= TX_READ;
                        r_rdAddr  <= '0;
                        r_beatCnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                TX_READ: begin
                    if (w_issue) begin
                        r_rdAddr <= r_rdAddr + CW'(1);
                        if (r_rdAddr == LAST_ADDR) begin
                            r_state <= TX_DRAIN;
                        end
                    end
                end
                TX_DRAIN: begin
                    if (w_finalBeat) begin
                        r_state <= TX_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

    // Sideband for the word in flight travels alongside it so it can be
    // pushed together with the BRAM data one cycle after the read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight     <= 1'b0;
            r_inflightLast <= 1'b0;
            r_inflightUser <= '0;
        end else begin
            r_inflight     <= w_issue;
            r_inflightLast <= w_issueLast;
            r_inflightUser <= w_issueUser;
        end
    end

    assign w_fifoIn = {bram_dout_i, r_inflightLast, r_inflightUser};

    cwt_skid_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_data  (w_fifoIn),
        .o_data  (w_fifoOut),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = w_fifoOut;
    assign m_axis_tvalid = !w_empty;
    assign busy_o        = r_busy;
    assign done_o        = r_done;

    // A word arriving at a full FIFO with nothing leaving would be lost.
    assert property (@(posedge clk) disable iff (!rstn) !(r_inflight && w_full && !w_pop));

endmodule

// File: doc/cwt_axis_tx.md
Name: cwt_axis_tx

Overview:
- Downstream drain stage for the CWT result BRAM.
- Triggered by a start pulse once all J1 scales of N coefficients are stored in BRAM.
- Owns the BRAM read port and reads every word exactly once, in address order.
- Emits the words as an AXI4-Stream master with full tready backpressure; busy_o drives the CWT control unit's downlink-busy input.

Parameters:
- N, 1024, samples per scale (power of two).
- J1, 64, number of scales (power of two).
- DW, 32, BRAM/stream data width.
- TLAST_MODE, 0, 0 = tlast on last word of frame; 1 = tlast on last word of each scale.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle pulse, begin draining a frame
- bram_en_o  out  1  BRAM read enable
- bram_addr_o  out  $clog2(N*J1)  BRAM read address
- bram_dout_i  in  DW  BRAM read data, valid exactly 1 cycle after bram_en_o
- m_axis_tdata  out  DW  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  end of packet per TLAST_MODE
- m_axis_tuser  out  $clog2(J1)  scale index of current beat (beat address >> $clog2(N))
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle pulse after final beat accepted

Behaviour:
Reset and framing:
- Reset (async, any time, including mid-frame): state IDLE, address and beat counters 0, in-flight flag 0, skid FIFO flushed.
- All outputs 0 during and after reset until the next start_i.
- No partial frame resumes after reset.
- Frame = N*J1 beats, addresses 0..N*J1-1 in ascending order, no gaps or duplicates.

FSM:
- IDLE: start_i=1 -> READ. start_i is ignored in every other state.
- READ: issues reads. After address N*J1-1 is issued -> DRAIN.
- DRAIN: no reads. When the last beat handshakes (tvalid & tready) -> IDLE.

Read issue rule:
- occ = fifo_count + inflight.
- bram_en_o=1 in READ when occ<2, or when occ==2 and a pop occurs this cycle.
- bram_addr_o = rd_addr whenever bram_en_o=1, otherwise 0.
- rd_addr increments on each issue.
- inflight register = bram_en_o delayed by 1 cycle. When set, bram_dout_i is pushed into the FIFO that cycle.
- The FIFO never overflows. Overflow is an assertion failure.

Skid FIFO:
- 2 entries, registered outputs.
- Each entry holds {data, last, user}; last and user are computed at issue time from rd_addr.
- tvalid = FIFO not empty; tdata/tlast/tuser = head entry.
- Pop on tvalid & tready. Simultaneous push and pop is allowed at any occupancy, including full.
- While tvalid=1 and tready=0, tdata/tlast/tuser hold stable (AXI rule). tvalid never drops without a handshake.

Latency:
- start_i sampled at edge k -> bram_en_o=1 with addr 0 in cycle k+1 -> push at edge k+2 -> tvalid=1 in cycle k+2 after that edge.
- With tready held 1: one beat per cycle sustained; last beat N*J1-1 cycles after the first.

tlast:
- TLAST_MODE=0: addr == N*J1-1.
- TLAST_MODE=1: addr[$clog2(N)-1:0] == N-1.

busy_o and done_o:
- busy_o = 1 from the cycle after start_i is accepted through the cycle of the final handshake.
- done_o = 1 for exactly one cycle, the cycle after the final handshake, coinciding with busy_o=0.

Width rules:
- Counters are $clog2(N*J1)+1 bits. Terminal detect uses equality, never wrap.
- N*J1-1 is the last address; the counter is not allowed to wrap to 0 before DRAIN.

Decomposition:
- Package cwt_pkg holds:
  - tx state encoding (IDLE, READ, DRAIN);
  - the address-width and scale-width functions based on $clog2;
  - the TLAST_MODE constants.
- One sub-module: cwt_skid_fifo, a 2-entry registered FIFO with parameter width DW+1+$clog2(J1), push/pop/full/empty/count.

Test Plan:
1. Test parameters N=8, J1=2, BRAM model dout=addr+0x100, tready=1, start pulse -> 16 consecutive beats with tdata 0x100..0x10F, tuser 0x8 then 1x8, tlast only on beat 15, done_o one cycle after beat 15, busy_o low with done_o.
2. Same setup, tready=0 for 5 cycles starting at beat 3 -> tdata 0x103 held stable with tvalid=1, bram_en_o=0 once occ==2, resume gives 0x104.. with no loss or duplication.
3. Random tready (50%), N=16, J1=4 -> scoreboard matches all 64 addresses in order, FIFO never overflows, exactly one done_o pulse.
4. TLAST_MODE=1, N=8, J1=2 -> tlast on beats 7 and 15 only.
5. start_i pulsed at beats 2 and 10 while busy -> ignored, still exactly 16 beats; new start after done_o -> second identical frame.
6. rstn low at beat 5 with tready toggling -> all outputs 0 immediately, FIFO empty; next start restarts at address 0, tdata 0x100.
